// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the burst RAM controller: FSM state encoding,
// default geometry and the read-buffer admission rule.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // A new read may be issued only if, after this cycle's pop, the buffered
  // entries plus the one already in flight leave room for one more.
  function automatic logic rd_slot_free(input logic [1:0] count,
                                        input logic       inflight,
                                        input logic       pop);
    logic [2:0] used_s;
    logic [2:0] limit_s;
    used_s  = {1'b0, count} + {2'b00, inflight};
    limit_s = 3'd2 + {2'b00, pop};
    return (used_s < limit_s);
  endfunction

endpackage

// File: rtl/ram_rd_skid_buf.sv
// Two-entry FIFO that catches RAM read data so that the consumer may stall
// without losing beats already requested from the RAM.
module ram_rd_skid_buf import ram_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  last_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign head_data = data_q[rd_ptr_q];
  assign head_last = last_q[rd_ptr_q];
  assign count     = count_q;

  // Qualify push/pop against occupancy and compute pointer/count updates.
  always_comb begin
    do_pop_s  = pop && (count_q != 2'd0);
    do_push_s = push && ((count_q != 2'd2) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset clears contents so head reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (do_push_s) begin
        data_q[wr_ptr_q] <= push_data;
        last_q[wr_ptr_q] <= push_last;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a synchronous single-port byte-enable RAM.
// Write bursts stream straight through to the RAM; read bursts are issued
// ahead into a two-entry buffer so the reader may apply backpressure.
module ram_burst_ctrl import ram_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  ram_ce,
  output logic [STRB_WIDTH-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic                  write_q, write_d;
  // One bit wider than the address so a full-depth burst can be counted.
  logic [ADDR_WIDTH:0]   beat_q, beat_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic                  in_write_s;
  logic                  in_read_s;
  logic                  wr_hs_s;
  logic                  last_beat_s;
  logic                  pop_s;
  logic                  issue_s;
  logic                  rd_done_s;
  logic                  wr_done_s;
  logic [1:0]            buf_count_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  head_last_s;

  // State and latched direction must agree before any RAM traffic is allowed.
  assign in_write_s  = (state_q == WRITE) && write_q;
  assign in_read_s   = (state_q == READ) && !write_q;
  assign wr_hs_s     = in_write_s && wr_valid;
  assign last_beat_s = (beat_q == {1'b0, len_q});
  assign wr_done_s   = wr_hs_s && last_beat_s;

  assign rd_valid    = (buf_count_s != 2'd0);
  assign pop_s       = rd_valid && rd_ready;
  assign rd_data     = head_data_s;
  assign rd_last     = rd_valid && head_last_s;
  assign rd_done_s   = in_read_s && pop_s && head_last_s;
  assign issue_s     = in_read_s && (beat_q <= {1'b0, len_q}) &&
                       rd_slot_free(buf_count_s, inflight_q, pop_s);

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wr_ready    = in_write_s;
  assign done        = rst_n && (wr_done_s || rd_done_s);

  assign ram_addr    = addr_q;
  assign ram_din     = wr_data;

  // RAM strobes: a write beat uses its byte enables (all-zero means no access
  // at all, so the RAM never sees a stray read); reset holds the RAM idle.
  always_comb begin
    ram_ce = 1'b0;
    ram_we = '0;
    if (!rst_n) begin
      ram_ce = 1'b0;
      ram_we = '0;
    end else if (wr_hs_s) begin
      ram_ce = |wr_strb;
      ram_we = wr_strb;
    end else if (issue_s) begin
      ram_ce = 1'b1;
      ram_we = '0;
    end else begin
      ram_ce = 1'b0;
      ram_we = '0;
    end
  end

  // Burst sequencing: command capture, beat counting, address advance.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    write_d         = write_q;
    beat_d          = beat_q;
    inflight_d      = issue_s;
    inflight_last_d = issue_s && last_beat_s;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          write_d = cmd_write;
          beat_d  = '0;
          state_d = cmd_write ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (wr_hs_s) begin
          addr_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          beat_d = beat_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if (last_beat_s) begin
            state_d = IDLE;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        if (issue_s) begin
          addr_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          beat_d = beat_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else begin
          beat_d = beat_q;
        end
        if (rd_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any burst and drops in-flight data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      write_q         <= 1'b0;
      beat_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      write_q         <= write_d;
      beat_q          <= beat_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  ram_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (ram_dout),
    .push_last (inflight_last_q),
    .pop       (pop_s),
    .head_data (head_data_s),
    .head_last (head_last_s),
    .count     (buf_count_s)
  );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl: a behavioural RAM, an expected
// memory image updated per burst, and directed plus randomized bursts.
module tb_ram_burst_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          ram_ce;
  logic [SW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          busy, done;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] exp_mem [256];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done)
  );

  // Synchronous single-port RAM with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we == 2'b00) begin
        ram_dout <= mem[ram_addr];
      end else begin
        for (int b = 0; b < SW; b++) begin
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cmd(input logic wr, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Write burst; rnd adds random data, strobes and idle gaps.
  task automatic do_write(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                          input bit rnd, input int zero_beat, input logic [DW-1:0] base);
    logic [AW-1:0] a;
    cmd(1'b1, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      if (rnd && ($urandom_range(0, 3) == 0)) begin
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_gap_ce", {31'd0, ram_ce}, 32'd0);
        chk("wr_gap_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
      end
      a        = addr + AW'(i);
      wr_valid = 1'b1;
      wr_data  = rnd ? DW'($urandom) : base + DW'(i);
      wr_strb  = rnd ? SW'($urandom_range(0, 3)) : 2'b11;
      if (i == zero_beat) wr_strb = 2'b00;
      @(negedge clk);
      chk("wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("wr_ce", {31'd0, ram_ce}, {31'd0, (wr_strb != 2'b00)});
      chk("wr_we", {30'd0, ram_we}, {30'd0, wr_strb});
      chk("wr_addr", {24'd0, ram_addr}, {24'd0, a});
      chk("wr_din", {16'd0, ram_din}, {16'd0, wr_data});
      chk("wr_done", {31'd0, done}, {31'd0, (i == int'(len))});
      for (int b = 0; b < SW; b++) begin
        if (wr_strb[b]) exp_mem[a][8*b +: 8] = wr_data[8*b +: 8];
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_end_busy", {31'd0, busy}, 32'd0);
    chk("wr_end_ready", {31'd0, wr_ready}, 32'd0);
    chk("wr_end_ce", {31'd0, ram_ce}, 32'd0);
  endtask

  // Read burst. mode 0: rd_ready=1, 1: pattern 1,0,0, 2: random.
  // rst_cycle>0 pulses rst_n low in that cycle and abandons the burst.
  task automatic do_read(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                         input int mode, input int rst_cycle);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] held_data;
    logic          held_last;
    bit            stalled = 1'b0;
    int            c = 1, beat = 0, issued = 0, popped = 0;
    int            budget;
    budget = (int'(len) + 1) * 4 + 20;
    for (int i = 0; i <= int'(len); i++) expq.push_back(exp_mem[addr + AW'(i)]);
    cmd(1'b0, addr, len);
    while (beat <= int'(len) && c < budget) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((c - 1) % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (c == rst_cycle) rst_n = 1'b0;
      @(negedge clk);
      chk("rd_we", {30'd0, ram_we}, 32'd0);
      if (ram_ce) issued++;
      if (c == rst_cycle) begin
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ce", {31'd0, ram_ce}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rd_ready = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_post_done", {31'd0, done}, 32'd0);
        return;
      end
      if (mode == 0 && c <= 3) chk("rd_latency", {31'd0, rd_valid}, {31'd0, (c == 3)});
      if (stalled && rd_valid) begin
        chk("rd_hold_data", {16'd0, rd_data}, {16'd0, held_data});
        chk("rd_hold_last", {31'd0, rd_last}, {31'd0, held_last});
      end
      if (rd_valid && rd_ready) begin
        chk("rd_data", {16'd0, rd_data}, {16'd0, expq[beat]});
        chk("rd_last", {31'd0, rd_last}, {31'd0, (beat == int'(len))});
        chk("rd_done", {31'd0, done}, {31'd0, (beat == int'(len))});
        if (mode == 0) chk("rd_thruput", 32'(c), 32'(3 + beat));
        beat++;
        popped++;
      end else begin
        chk("rd_nodone", {31'd0, done}, 32'd0);
      end
      // Buffered entries plus the in-flight read may never exceed two.
      chk("rd_outstanding", {31'd0, ((issued - popped) <= 2)}, 32'd1);
      stalled   = rd_valid && !rd_ready;
      held_data = rd_data;
      held_last = rd_last;
      @(posedge clk); #1;
      c++;
    end
    if (beat <= int'(len)) chk("rd_timeout", 32'(beat), 32'(int'(len) + 1));
    rd_ready = 1'b0;
    @(negedge clk);
    chk("rd_issued", 32'(issued), 32'(int'(len) + 1));
    chk("rd_end_busy", {31'd0, busy}, 32'd0);
    chk("rd_end_valid", {31'd0, rd_valid}, 32'd0);
    chk("rd_end_ce", {31'd0, ram_ce}, 32'd0);
  endtask

  initial begin
    logic [AW-1:0] ra, rl;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = DW'($urandom);
      exp_mem[i] = mem[i];
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rd_last", {31'd0, rd_last}, 32'd0);
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("reset_ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("reset_ram_we", {30'd0, ram_we}, 32'd0);
    chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
    rst_n = 1'b1;

    do_write(8'h10, 8'd3, 1'b0, -1, 16'hA000);
    do_read(8'h10, 8'd3, 0, 0);
    do_read(8'h10, 8'd3, 1, 0);
    do_write(8'hFE, 8'd3, 1'b0, 2, 16'hB000);
    do_read(8'hFE, 8'd3, 2, 0);
    do_read(8'h10, 8'd0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      ra = AW'($urandom);
      rl = AW'($urandom_range(0, 15));
      do_write(ra, rl, 1'b1, -1, 16'h0000);
      do_read(ra, rl, k % 3, 0);
    end

    do_write(8'h80, 8'hFF, 1'b1, -1, 16'h0000);
    do_read(8'h80, 8'hFF, 2, 0);
    do_read(8'h00, 8'hFF, 0, 0);

    do_read(8'h20, 8'd7, 0, 4);
    do_read(8'h11, 8'd0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
